axi_mem_bridge: RTL and testbench
=================================

AXI_MEM_BRIDGE -- requirements
Module: axi_mem_bridge

Interface
REQ-001 Parameters: ADDR_W, default 32, AXI address width; DATA_W, default 32, beat width in bits; BEATS, default 16, beats per cache line (power of 2, 2..256).
REQ-002 clk  in  1  clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 addr_valid_in  in  1  controller requests a line transfer; held until accepted.
REQ-005 rw_in  in  1  1 = write-back, 0 = load; sampled with addr_valid_in.
REQ-006 addr_in  in  ADDR_W  line-aligned byte address; sampled with addr_valid_in.
REQ-007 valid_wb  in  1  controller presenting write-back data.
REQ-008 wb_data  in  DATA_W  write-back beat.
REQ-009 ready_wb  out  1  write-back request accepted; beat 0 captured this cycle.
REQ-010 ready_ld  in  1  controller able to take load data.
REQ-011 valid_ld  out  1  load data beat valid.
REQ-012 ld_data  out  DATA_W  load beat.
REQ-013 AXI4 master: awaddr/awlen/awsize/awburst/awvalid out, awready in; wdata/wstrb/wlast/wvalid out, wready in; bresp in 2, bvalid in, bready out; araddr/arlen/arsize/arburst/arvalid out, arready in; rdata/rresp/rlast/rvalid in, rready out.
REQ-014 bus_err  out  1  one-cycle pulse on any non-OKAY bresp/rresp.

Function
REQ-015 States SHALL be IDLE, WCAP, AW, WSEND, WRESP, AR, RCOL, RSTREAM; one-hot or binary at implementer's choice.
REQ-016 Bursts SHALL use awlen/arlen = BEATS-1, awsize/arsize = log2(DATA_W/8), burst INCR, wstrb all ones.
REQ-017 IDLE, addr_valid_in && rw_in: latch addr_in, drive ready_wb=1 for exactly one cycle, capture wb_data into buffer[0], go WCAP.
REQ-018 WCAP: capture wb_data into buffer[1..BEATS-1] on the BEATS-1 consecutive cycles after the ready_wb cycle, unconditionally (no backpressure to controller); then go AW.
REQ-019 AW: awvalid=1 with latched address until awready; then WSEND.
REQ-020 WSEND: stream buffer[0..BEATS-1] on W; advance only on wvalid && wready; wlast=1 on beat BEATS-1; after last handshake go WRESP.
REQ-021 WRESP: bready=1; on bvalid go IDLE; bus_err pulse if bresp != 0.
REQ-022 IDLE, addr_valid_in && !rw_in: latch address, go AR; arvalid=1 until arready, then RCOL.
REQ-023 RCOL: rready=1; store rdata into buffer[beat] on each rvalid handshake; on rlast handshake go RSTREAM; rlast arriving before beat BEATS-1 or not on beat BEATS-1 SHALL set bus_err.
REQ-024 RSTREAM: wait for ready_ld; then valid_ld=1 with buffer[0], followed by buffer[1..BEATS-1] on the next BEATS-1 consecutive cycles (valid_ld high throughout, no gaps); then IDLE.
REQ-025 One transaction outstanding at a time; addr_valid_in ignored outside IDLE; a load following a write-back SHALL not issue AR before WRESP completes.
REQ-026 Beat counter width clog2(BEATS)+1; wraps to 0 on every state exit.
REQ-027 AXI valid signals SHALL not deassert before their handshake; payload stable while valid and not ready.
REQ-028 Single-port line buffer BEATS x DATA_W shared by write and load paths.

Reset
REQ-029 rst_n=0 on any clock edge: state IDLE, counters 0, all outputs 0 (ready_wb, valid_ld, awvalid, wvalid, wlast, bready, arvalid, rready, bus_err, ld_data); buffer contents need not reset.
REQ-030 Reset mid-burst SHALL abandon the transaction immediately; no AXI handshake completes after reset assertion.

Verification
REQ-031 Write-back 0x1000, wb_data=i on beat i, awready/wready always 1 -> ready_wb pulse, AW addr 0x1000 len 15, W beats 0..15, wlast on beat 15, bready, back to IDLE.
REQ-032 Write with wready toggling 1/0 every cycle -> W data order 0..15 preserved, 16 handshakes, wlast only on 16th.
REQ-033 Load 0x2000, rdata=0xA0+i with random rvalid gaps -> after ready_ld, valid_ld 16 consecutive cycles, ld_data 0xA0..0xAF in order.
REQ-034 Write-back then immediate load request -> arvalid not asserted until bvalid handshake done.
REQ-035 bresp=2 (SLVERR) -> bus_err one-cycle pulse, FSM returns IDLE.
REQ-036 rst_n=0 during RCOL beat 7 -> next cycle all outputs 0, state IDLE; subsequent load completes normally.

Source files
------------

// File: rtl/axi_mem_bridge.sv
// axi_mem_bridge: moves one cache line at a time between a cache controller and an AXI4 slave.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   addr_valid_in/rw_in/addr_in line request (1 = write-back, 0 = load), held until accepted
//   valid_wb/wb_data/ready_wb   write-back beats; ready_wb pulses when beat 0 is captured
//   ready_ld/valid_ld/ld_data   load beats streamed back-to-back once ready_ld is seen
//   aw*/w*/b*/ar*/r*            AXI4 master channels, INCR bursts of BEATS beats
//   bus_err                     one-cycle pulse on a non-OKAY response or misplaced rlast
module axi_mem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_valid_in,
    input  logic              rw_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              valid_wb,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ready_wb,
    input  logic              ready_ld,
    output logic              valid_ld,
    output logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              bus_err
);
    localparam int LW = $clog2(BEATS);
    localparam int CW = LW + 1;

    typedef enum logic [2:0] {IDLE, WCAP, AW, WSEND, WRESP, AR, RCOL, RSTREAM} state_t;

    state_t            st, nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] buffer [BEATS];
    logic [LW-1:0]     widx;
    logic [DATA_W-1:0] wdat;
    logic              we, ld_load, err_nxt, addr_ld, last;
    logic              unused;

    // Write-back data is captured on fixed cycles, so valid_wb carries no extra information.
    assign unused  = valid_wb;
    assign last    = cnt == CW'(BEATS - 1);
    assign awaddr  = addr;
    assign araddr  = addr;
    assign awlen   = 8'(BEATS - 1);
    assign arlen   = 8'(BEATS - 1);
    assign awsize  = 3'($clog2(DATA_W / 8));
    assign arsize  = 3'($clog2(DATA_W / 8));
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = '1;
    assign wdata   = buffer[cnt[LW-1:0]];
    assign wlast   = wvalid && last;

    always_ff @(posedge clk)
        if (!rst_n) st <= IDLE;
        else        st <= nxt;

    always_comb begin
        nxt      = st;
        cnt_nxt  = cnt;
        ready_wb = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        we       = 1'b0;
        widx     = cnt[LW-1:0];
        wdat     = wb_data;
        ld_load  = 1'b0;
        err_nxt  = 1'b0;
        addr_ld  = 1'b0;
        case (st)
            IDLE: if (addr_valid_in) begin
                addr_ld = 1'b1;
                if (rw_in) begin
                    ready_wb = 1'b1;
                    we       = 1'b1;
                    widx     = '0;
                    cnt_nxt  = CW'(1);
                    nxt      = WCAP;
                end else nxt = AR;
            end
            WCAP: begin
                we      = 1'b1;
                cnt_nxt = last ? '0 : cnt + CW'(1);
                nxt     = last ? AW : WCAP;
            end
            AW: begin
                awvalid = 1'b1;
                nxt     = awready ? WSEND : AW;
            end
            WSEND: begin
                wvalid = 1'b1;
                if (wready) begin
                    cnt_nxt = last ? '0 : cnt + CW'(1);
                    nxt     = last ? WRESP : WSEND;
                end
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_nxt = bresp != 2'b00;
                    nxt     = IDLE;
                end
            end
            AR: begin
                arvalid = 1'b1;
                nxt     = arready ? RCOL : AR;
            end
            RCOL: begin
                rready = 1'b1;
                if (rvalid) begin
                    we      = 1'b1;
                    wdat    = rdata;
                    // rlast must coincide exactly with the final beat of the line
                    err_nxt = (rresp != 2'b00) || (rlast != last);
                    cnt_nxt = rlast ? '0 : cnt + CW'(1);
                    nxt     = rlast ? RSTREAM : RCOL;
                end
            end
            RSTREAM: if (cnt != '0 || ready_ld) begin
                ld_load = 1'b1;
                cnt_nxt = last ? '0 : cnt + CW'(1);
                nxt     = last ? IDLE : RSTREAM;
            end
            default: nxt = IDLE;
        endcase
        // Drop every handshake output while reset is asserted so no AXI transfer completes on the reset edge.
        if (!rst_n) begin
            ready_wb = 1'b0;
            awvalid  = 1'b0;
            wvalid   = 1'b0;
            bready   = 1'b0;
            arvalid  = 1'b0;
            rready   = 1'b0;
            we       = 1'b0;
            ld_load  = 1'b0;
            err_nxt  = 1'b0;
            addr_ld  = 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            cnt      <= '0;
            addr     <= '0;
            bus_err  <= 1'b0;
            valid_ld <= 1'b0;
            ld_data  <= '0;
        end else begin
            cnt      <= cnt_nxt;
            bus_err  <= err_nxt;
            valid_ld <= ld_load;
            if (addr_ld) addr <= addr_in;
            if (ld_load) ld_data <= buffer[cnt[LW-1:0]];
        end

    always_ff @(posedge clk)
        if (we) buffer[widx] <= wdat;
endmodule

// File: tb/tb_axi_mem_bridge.sv
// tb_axi_mem_bridge: directed self-checking bench for axi_mem_bridge with a hand-driven AXI slave.
module tb_axi_mem_bridge;
    logic        clk = 1'b0;
    logic        rst_n, addr_valid_in, rw_in, valid_wb, ready_ld;
    logic [31:0] addr_in, wb_data;
    logic        ready_wb, valid_ld;
    logic [31:0] ld_data;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready, bus_err;
    int          n_assert = 0;
    int          n_fail = 0;

    wire [40:0] outs = {ready_wb, valid_ld, awvalid, wvalid, wlast, bready, arvalid, rready, bus_err, ld_data};

    always #5 clk = ~clk;

    axi_mem_bridge dut (
        .clk(clk), .rst_n(rst_n), .addr_valid_in(addr_valid_in), .rw_in(rw_in), .addr_in(addr_in),
        .valid_wb(valid_wb), .wb_data(wb_data), .ready_wb(ready_wb), .ready_ld(ready_ld),
        .valid_ld(valid_ld), .ld_data(ld_data),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] base, input bit tog,
                            input logic [1:0] br, input bit pend);
        int nb;
        bit ar_seen;
        ar_seen = 1'b0;
        addr_valid_in = 1'b1; rw_in = 1'b1; addr_in = a; valid_wb = 1'b1; wb_data = base;
        #1 chk("wb_ready_pulse", ready_wb, 1);
        @(negedge clk);
        if (pend) begin rw_in = 1'b0; addr_in = 32'h3000; end
        else addr_valid_in = 1'b0;
        for (int i = 1; i < 16; i++) begin
            wb_data = base + i;
            #1 if (i == 1) chk("wb_ready_low", ready_wb, 0);
            @(negedge clk);
        end
        valid_wb = 1'b0;
        for (int t = 0; t < 10 && !awvalid; t++) @(negedge clk);
        chk("aw_valid", awvalid, 1);
        chk("aw_addr", awaddr, a);
        chk("aw_len", awlen, 15);
        chk("aw_size", awsize, 2);
        chk("aw_burst", awburst, 1);
        chk("w_strb", wstrb, 4'hF);
        ar_seen |= arvalid;
        @(negedge clk);
        nb = 0;
        wready = 1'b1;
        for (int t = 0; t < 100 && nb < 16; t++) begin
            if (tog && t > 0) wready = ~wready;
            ar_seen |= arvalid;
            if (wvalid && wready) begin
                chk("w_data", wdata, base + nb);
                chk("w_last", wlast, nb == 15);
                nb++;
            end
            @(negedge clk);
        end
        wready = 1'b1;
        chk("w_count", nb, 16);
        chk("w_idle", wvalid, 0);
        bvalid = 1'b1; bresp = br;
        chk("b_ready", bready, 1);
        ar_seen |= arvalid;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        chk("bus_err_pulse", bus_err, br != 2'b00);
        chk("b_done", bready, 0);
        ar_seen |= arvalid;
        @(negedge clk);
        chk("bus_err_clear", bus_err, 0);
        if (pend) chk("ar_held_off", ar_seen, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] base, input bit req_done, input int rst_beat);
        int k;
        if (!req_done) begin addr_valid_in = 1'b1; rw_in = 1'b0; addr_in = a; end
        for (int t = 0; t < 40 && !arvalid; t++) @(negedge clk);
        chk("ar_valid", arvalid, 1);
        chk("ar_addr", araddr, a);
        chk("ar_len", arlen, 15);
        chk("ar_size", arsize, 2);
        chk("ar_burst", arburst, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; addr_valid_in = 1'b0;
        k = 0;
        for (int t = 0; t < 100 && k < 16; t++) begin
            rvalid = (t % 3 != 1); rdata = base + k; rlast = (k == 15); rresp = 2'b00;
            if (k == rst_beat && rvalid) begin
                rst_n = 1'b0;
                #1 chk("rst_rready_drop", rready, 0);
                @(negedge clk);
                chk("rst_outs", outs, 0);
                rst_n = 1'b1; rvalid = 1'b0; rlast = 1'b0;
                @(negedge clk);
                chk("rst_idle", outs, 0);
                return;
            end
            if (rvalid) begin
                chk("r_ready", rready, 1);
                k++;
            end
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        chk("r_count", k, 16);
        chk("r_no_err", bus_err, 0);
        repeat (3) begin
            chk("ld_wait", valid_ld, 0);
            @(negedge clk);
        end
        ready_ld = 1'b1;
        @(negedge clk);
        ready_ld = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("ld_valid", valid_ld, 1);
            chk("ld_data", ld_data, base + j);
            @(negedge clk);
        end
        chk("ld_done", valid_ld, 0);
    endtask

    initial begin
        rst_n = 1'b0; addr_valid_in = 1'b0; rw_in = 1'b0; addr_in = '0; valid_wb = 1'b0; wb_data = '0;
        ready_ld = 1'b0; awready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs, 0);
        do_write(32'h1000, 32'h0, 1'b0, 2'b00, 1'b0);
        do_write(32'h1400, 32'h100, 1'b1, 2'b00, 1'b0);
        do_load(32'h2000, 32'hA0, 1'b0, -1);
        do_write(32'h1800, 32'h200, 1'b0, 2'b00, 1'b1);
        do_load(32'h3000, 32'hC0, 1'b1, -1);
        do_write(32'h1C00, 32'h300, 1'b0, 2'b10, 1'b0);
        do_load(32'h4000, 32'hE0, 1'b0, 7);
        do_load(32'h5000, 32'h50, 1'b0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
